// File: rtl/axi_burst_rd_engine.sv
// AXI4 burst read engine: splits a beat-count transfer into INCR bursts
// (capped by MAX_BURST and 4 KB boundaries) and streams read data into a
// local buffer write port.
// Optional build macro: BURST_RD_RRESP_CHK_EN enables the sticky RRESP error flag.
module axi_burst_rd_engine #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned BUF_AW    = 10
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    xfer_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [7:0]          M_AXI_ARLEN,
    output logic [2:0]          M_AXI_ARSIZE,
    output logic [1:0]          M_AXI_ARBURST,
    output logic [3:0]          M_AXI_ARID,
    output logic                M_AXI_ARLOCK,
    output logic [3:0]          M_AXI_ARCACHE,
    output logic [2:0]          M_AXI_ARPROT,
    output logic [3:0]          M_AXI_ARQOS,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RLAST,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY,
    output logic [BUF_AW-1:0]   wr_addr,
    output logic                wr_en,
    output logic [DATA_W-1:0]   wr_data
);

    localparam int unsigned BYTE_W   = DATA_W / 8;
    localparam int unsigned SIZE_LOG = $clog2(BYTE_W);
    localparam int unsigned CNT_W    = ((LEN_W > 13) ? LEN_W : 13) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    remaining;
    logic [LEN_W-1:0]    rem_after;
    logic [12:0]         bytes_to_4k;
    logic [CNT_W-1:0]    beats_to_4k;
    logic [CNT_W-1:0]    beats_cap;
    logic [CNT_W-1:0]    burst_beats;
    logic                accept;
    logic                rd_beat;
    logic                last_beat;

    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARSIZE  = 3'(SIZE_LOG);
    assign M_AXI_ARBURST = 2'b01;

    assign accept    = (state == ST_IDLE) && start;
    assign rd_beat   = (state == ST_R) && M_AXI_RVALID;
    assign last_beat = rd_beat && M_AXI_RLAST;
    assign rem_after = remaining - LEN_W'(burst_beats);

    // Burst size: smallest of remaining beats, MAX_BURST and beats left in the 4 KB page
    always_comb begin
        bytes_to_4k = 13'h1000 - {1'b0, cur_addr[11:0]};
        beats_to_4k = CNT_W'(bytes_to_4k >> SIZE_LOG);
        beats_cap   = (CNT_W'(remaining) < CNT_W'(MAX_BURST)) ? CNT_W'(remaining)
                                                               : CNT_W'(MAX_BURST);
        burst_beats = (beats_to_4k < beats_cap) ? beats_to_4k : beats_cap;
    end

    // State register
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (xfer_len == '0) ? ST_DONE : ST_AR;
            ST_AR:   if (M_AXI_ARREADY) state_nxt = ST_R;
            ST_R:    if (last_beat) state_nxt = (rem_after == '0) ? ST_DONE : ST_AR;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; AR payload comes straight from the address/count registers
    always_comb begin
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        M_AXI_ARVALID = (state == ST_AR);
        M_AXI_RREADY  = (state == ST_R);
        M_AXI_ARADDR  = cur_addr;
        M_AXI_ARLEN   = 8'(burst_beats - CNT_W'(1));
    end

    // Transfer bookkeeping and buffer write port
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            cur_addr  <= '0;
            remaining <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= rd_beat;
            if (rd_beat) wr_data <= M_AXI_RDATA;
            if (accept) begin
                cur_addr  <= base_addr & ~ADDR_W'(BYTE_W - 1);
                remaining <= xfer_len;
                wr_addr   <= '0;
            end else begin
                if (wr_en) wr_addr <= wr_addr + BUF_AW'(1);
                if (last_beat) begin
                    remaining <= rem_after;
                    cur_addr  <= cur_addr + (ADDR_W'(burst_beats) << SIZE_LOG);
                end
            end
        end
    end

`ifdef BURST_RD_RRESP_CHK_EN
    // Sticky SLVERR/DECERR flag, cleared by the next accepted start
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN)               err <= 1'b0;
        else if (accept)                  err <= 1'b0;
        else if (rd_beat && M_AXI_RRESP[1]) err <= 1'b1;
    end

    logic unused_rresp;
    assign unused_rresp = M_AXI_RRESP[0];
`else
    assign err = 1'b0;

    logic [1:0] unused_rresp;
    assign unused_rresp = M_AXI_RRESP;
`endif

endmodule

// File: tb/tb_axi_burst_rd_engine.sv
// Bench for axi_burst_rd_engine: randomised AXI read slave plus a burst-split
// and data-order reference model.
module tb_axi_burst_rd_engine;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned BUF_AW    = 10;
    localparam int unsigned BYTES     = DATA_W / 8;
`ifdef BURST_RD_RRESP_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic               start = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [LEN_W-1:0]   xfer_len = '0;
    logic               busy, done, err;
    logic [ADDR_W-1:0]  ARADDR;
    logic [7:0]         ARLEN;
    logic [2:0]         ARSIZE, ARPROT;
    logic [1:0]         ARBURST;
    logic [3:0]         ARID, ARCACHE, ARQOS;
    logic               ARLOCK, ARVALID, RREADY;
    logic               ARREADY = 1'b0;
    logic [DATA_W-1:0]  RDATA = '0;
    logic [1:0]         RRESP = 2'b00;
    logic               RLAST = 1'b0;
    logic               RVALID = 1'b0;
    logic [BUF_AW-1:0]  wr_addr;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;

    axi_burst_rd_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST),
        .LEN_W(LEN_W), .BUF_AW(BUF_AW)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
        .start(start), .base_addr(base_addr), .xfer_len(xfer_len),
        .busy(busy), .done(done), .err(err),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
        .M_AXI_ARBURST(ARBURST), .M_AXI_ARID(ARID), .M_AXI_ARLOCK(ARLOCK),
        .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT), .M_AXI_ARQOS(ARQOS),
        .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration and observations
    int ar_delay = 0, rgap_pct = 0, err_beat = -1;
    int ar_wait = 0, pend_beats = 0, beat_idx = 0;
    int done_cnt = 0, arv_cnt = 0, ar_unstable = 0, ar_bad_attr = 0, rr_bad = 0, wr_in_done = 0;
    logic [ADDR_W-1:0] ar_first_addr;
    logic [7:0]        ar_first_len;
    logic [ADDR_W-1:0] ar_addr_q[$];
    logic [7:0]        ar_len_q[$];
    logic [BUF_AW-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    logic [DATA_W-1:0] sent_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI read slave and output monitor; inputs change only on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
                ar_wait = 0; pend_beats = 0;
                continue;
            end
            if (wr_en) begin
                wr_addr_q.push_back(wr_addr);
                wr_data_q.push_back(wr_data);
            end
            if (done) begin
                done_cnt++;
                if (wr_en) wr_in_done++;
            end
            // R channel: only bursts already granted on AR
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
            if (pend_beats > 0 && $urandom_range(99) >= rgap_pct) begin
                RVALID = 1'b1;
                RDATA  = {$urandom, $urandom};
                RLAST  = (pend_beats == 1);
                RRESP  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                if (RREADY) begin
                    sent_q.push_back(RDATA);
                    pend_beats--;
                    beat_idx++;
                end
            end
            // AR channel with programmable ready delay
            ARREADY = 1'b0;
            if (ARVALID) begin
                arv_cnt++;
                if (RREADY) rr_bad++;
                if (ar_wait == 0) begin
                    ar_first_addr = ARADDR;
                    ar_first_len  = ARLEN;
                end else if (ARADDR !== ar_first_addr || ARLEN !== ar_first_len) begin
                    ar_unstable++;
                end
                if (ar_wait >= ar_delay) begin
                    ARREADY = 1'b1;
                    ar_addr_q.push_back(ARADDR);
                    ar_len_q.push_back(ARLEN);
                    if (ARSIZE !== 3'd3 || ARBURST !== 2'b01) ar_bad_attr++;
                    pend_beats = int'(ARLEN) + 1;
                    ar_wait = 0;
                end else begin
                    ar_wait++;
                end
            end
        end
    end

    // One transfer: drive start, wait for done, compare against the reference model
    task automatic run_xfer(input logic [31:0] base, input int len, input int dly,
                            input int gap, input int errb, input bit inj_busy_start);
        logic [31:0] exp_addr[$];
        int          exp_len[$];
        logic [31:0] a;
        int          rem, b, to4k, cyc;
        logic [63:0] exp_d;

        a = base & ~32'(BYTES - 1);
        rem = len;
        while (rem > 0) begin
            to4k = (4096 - int'(a % 4096)) / int'(BYTES);
            b = rem;
            if (b > int'(MAX_BURST)) b = int'(MAX_BURST);
            if (b > to4k) b = to4k;
            exp_addr.push_back(a);
            exp_len.push_back(b - 1);
            rem -= b;
            a += 32'(b * int'(BYTES));
        end

        ar_addr_q.delete(); ar_len_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); sent_q.delete();
        done_cnt = 0; arv_cnt = 0; ar_unstable = 0; ar_bad_attr = 0; rr_bad = 0;
        wr_in_done = 0; beat_idx = 0;
        ar_delay = dly; rgap_pct = gap; err_beat = errb;

        @(negedge clk);
        start = 1'b1; base_addr = base; xfer_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        if (len == 0) begin
            check("zero_len_done", 64'(done), 64'd1);
            check("zero_len_arvalid", 64'(ARVALID), 64'd0);
        end else begin
            check("first_cycle_busy_arvalid", 64'({busy, ARVALID}), 64'b11);
            check("err_cleared_on_start", 64'(err), 64'd0);
            if (inj_busy_start) begin
                @(negedge clk);
                start = 1'b1; base_addr = 32'h0000_5000; xfer_len = LEN_W'(3);
                @(negedge clk);
                start = 1'b0;
            end
            cyc = 0;
            while (done !== 1'b1 && cyc < 20000) begin
                @(negedge clk);
                cyc++;
            end
            check("done_seen", 64'(done), 64'd1);
        end
        @(negedge clk);
        check("done_one_cycle_busy_low", 64'({done, busy}), 64'b00);
        @(negedge clk);

        check("ar_count", 64'(ar_addr_q.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < ar_addr_q.size(); i++) begin
            check("araddr", 64'(ar_addr_q[i]), 64'(exp_addr[i]));
            check("arlen", 64'(ar_len_q[i]), 64'(exp_len[i]));
        end
        check("ar_stable", 64'(ar_unstable), 64'd0);
        check("ar_attr", 64'(ar_bad_attr), 64'd0);
        check("rready_outside_r", 64'(rr_bad), 64'd0);
        check("beats_sent", 64'(sent_q.size()), 64'(len));
        check("wr_count", 64'(wr_data_q.size()), 64'(len));
        for (int i = 0; i < wr_data_q.size(); i++) begin
            exp_d = (i < sent_q.size()) ? sent_q[i] : 64'hDEAD_BEEF_DEAD_BEEF;
            check("wr_addr", 64'(wr_addr_q[i]), 64'(i % (1 << BUF_AW)));
            check("wr_data", 64'(wr_data_q[i]), exp_d);
        end
        check("done_count", 64'(done_cnt), 64'd1);
        check("last_wr_in_done", 64'(wr_in_done), (len > 0) ? 64'd1 : 64'd0);
        if (len == 0) check("no_ar_traffic", 64'(arv_cnt), 64'd0);
        check("err_flag", 64'(err), (CHK && errb >= 0 && errb < len) ? 64'd1 : 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_rready", 64'(RREADY), 64'd0);
        check("rst_wr", 64'({wr_en, wr_addr}), 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(32'h0000_1000, 16, 0, 0, -1, 1'b0);
        run_xfer(32'h0000_0FF0, 8, 0, 0, -1, 1'b0);
        run_xfer(32'h0000_2000, 40, 3, 0, -1, 1'b1);
        run_xfer(32'h0000_3000, 0, 0, 0, -1, 1'b0);
        run_xfer(32'h0000_1000, 16, 0, 20, 2, 1'b0);
        run_xfer(32'h0000_1000, 16, 1, 10, -1, 1'b0);
        run_xfer(32'h0001_2345, 1030, 0, 0, -1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_xfer($urandom_range(32'h000F_FFFF, 0), int'($urandom_range(70, 1)),
                     int'($urandom_range(3, 0)), int'($urandom_range(40, 0)),
                     int'($urandom_range(20, 0)) - 5, 1'b0);
        end

        // mid-transfer reset aborts everything
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_3000; xfer_len = LEN_W'(20);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy_done", 64'({busy, done}), 64'd0);
        check("midrst_axi", 64'({ARVALID, RREADY}), 64'd0);
        check("midrst_wr", 64'({wr_en, wr_addr}), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        rstn = 1'b1;
        arv_cnt = 0; done_cnt = 0; wr_data_q.delete();
        repeat (10) @(negedge clk);
        check("post_rst_no_ar", 64'(arv_cnt), 64'd0);
        check("post_rst_no_wr", 64'(wr_data_q.size()), 64'd0);
        check("post_rst_no_done", 64'(done_cnt), 64'd0);

        run_xfer(32'h0000_0FF8, 5, 2, 15, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
